// File: rtl/core_seq_pkg.sv
// Shared types and constants for the NPU run sequencer.
package core_seq_pkg;

  localparam int unsigned COL       = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DRAIN_CYC = 10;
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned INST_W    = 20;

  // Core instruction word bit positions
  localparam int unsigned INST_SFP_WR2PMEM = 19;
  localparam int unsigned INST_SFP_DIV     = 18;
  localparam int unsigned INST_SFP_ACC     = 17;
  localparam int unsigned INST_OFIFO_RD    = 16;
  localparam int unsigned INST_QK_ADD_LSB  = 12;
  localparam int unsigned INST_P_ADD_LSB   = 8;
  localparam int unsigned INST_EXECUTE     = 7;
  localparam int unsigned INST_LOAD        = 6;
  localparam int unsigned INST_QMEM_RD     = 5;
  localparam int unsigned INST_QMEM_WR     = 4;
  localparam int unsigned INST_KMEM_RD     = 3;
  localparam int unsigned INST_KMEM_WR     = 2;
  localparam int unsigned INST_PMEM_RD     = 1;
  localparam int unsigned INST_PMEM_WR     = 0;

  typedef enum logic [3:0] {
    IDLE, WR_K, WR_Q, LD_K, EXEC, DRAIN, OFIFO, ACC, DIV, DONE
  } state_t;

  // DIV row sub-steps: read pmem, divide, write back
  typedef enum logic [1:0] {
    SUB_R, SUB_D, SUB_W
  } substep_t;

endpackage

// File: rtl/core_seq_if.sv
// Host-side handshake and instruction bus of the sequencer.
interface core_seq_if;
  logic                                 start;
  logic [core_seq_pkg::ADDR_W-1:0]      len_m1;
  logic                                 ext_req;
  logic                                 ext_vld;
  logic [core_seq_pkg::INST_W-1:0]      inst;
  logic                                 busy;
  logic                                 done;

  modport master (output start, len_m1, ext_vld, input ext_req, inst, busy, done);
  modport slave  (input start, len_m1, ext_vld, output ext_req, inst, busy, done);
endinterface

// File: rtl/core_seq_inst_enc.sv
// Combinational decode of sequencer state into the core instruction word.
module core_seq_inst_enc
  import core_seq_pkg::*;
(
  input  state_t              state,
  input  substep_t            sub,
  input  logic [CNT_W-1:0]    cnt,
  input  logic [ADDR_W-1:0]   len,
  input  logic                ext_vld,
  output logic [INST_W-1:0]   inst
);

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  last_row;

  assign addr     = cnt[ADDR_W-1:0];
  assign last_row = {1'b0, len};

  // Per-state instruction bits; anything not named stays zero
  always_comb begin
    inst = '0;
    case (state)
      WR_K: begin
        if (ext_vld) begin
          inst[INST_KMEM_WR] = 1'b1;
          inst[INST_QK_ADD_LSB +: ADDR_W] = addr;
        end
      end
      WR_Q: begin
        if (ext_vld) begin
          inst[INST_QMEM_WR] = 1'b1;
          inst[INST_QK_ADD_LSB +: ADDR_W] = addr;
        end
      end
      LD_K: begin
        // Final cycle keeps load high to cover the SRAM read latency
        inst[INST_LOAD] = 1'b1;
        if (cnt < CNT_W'(COL)) begin
          inst[INST_KMEM_RD] = 1'b1;
          inst[INST_QK_ADD_LSB +: ADDR_W] = addr;
        end
      end
      EXEC: begin
        inst[INST_EXECUTE] = 1'b1;
        if (cnt <= last_row) begin
          inst[INST_QMEM_RD] = 1'b1;
          inst[INST_QK_ADD_LSB +: ADDR_W] = addr;
        end
      end
      OFIFO: begin
        inst[INST_OFIFO_RD] = 1'b1;
        inst[INST_PMEM_WR]  = 1'b1;
        inst[INST_P_ADD_LSB +: ADDR_W] = addr;
      end
      ACC: begin
        // Accumulate trails the pmem read by one cycle
        if (cnt <= last_row) begin
          inst[INST_PMEM_RD] = 1'b1;
          inst[INST_P_ADD_LSB +: ADDR_W] = addr;
        end
        if (cnt != '0) inst[INST_SFP_ACC] = 1'b1;
      end
      DIV: begin
        case (sub)
          SUB_R: begin
            inst[INST_PMEM_RD] = 1'b1;
            inst[INST_P_ADD_LSB +: ADDR_W] = addr;
          end
          SUB_D: inst[INST_SFP_DIV] = 1'b1;
          SUB_W: begin
            inst[INST_PMEM_WR]     = 1'b1;
            inst[INST_SFP_WR2PMEM] = 1'b1;
            inst[INST_P_ADD_LSB +: ADDR_W] = addr;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Run sequencer: steps one attention pass and drives the core instruction word.
module core_seq_ctrl
  import core_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  core_seq_if.slave  bus
);

  state_t             state;
  substep_t           sub;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  len;
  logic               busy_q;
  logic [CNT_W-1:0]   last_row;

  assign last_row = {1'b0, len};

  // Run FSM with phase counter and DIV sub-step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sub    <= SUB_R;
      cnt    <= '0;
      len    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len    <= bus.len_m1;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= WR_K;
          end
        end
        WR_K: begin
          if (bus.ext_vld) begin
            if (cnt == CNT_W'(COL - 1)) begin
              cnt   <= '0;
              state <= WR_Q;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        WR_Q: begin
          if (bus.ext_vld) begin
            if (cnt == last_row) begin
              cnt   <= '0;
              state <= LD_K;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LD_K: begin
          if (cnt == CNT_W'(COL)) begin
            cnt   <= '0;
            state <= EXEC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EXEC: begin
          if (cnt == last_row + CNT_W'(1)) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
            cnt   <= '0;
            state <= OFIFO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OFIFO: begin
          if (cnt == last_row) begin
            cnt   <= '0;
            state <= ACC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACC: begin
          if (cnt == last_row + CNT_W'(1)) begin
            cnt   <= '0;
            sub   <= SUB_R;
            state <= DIV;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          case (sub)
            SUB_R: sub <= SUB_D;
            SUB_D: sub <= SUB_W;
            default: begin
              sub <= SUB_R;
              if (cnt == last_row) begin
                cnt   <= '0;
                state <= DONE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          endcase
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  core_seq_inst_enc u_enc (
    .state   (state),
    .sub     (sub),
    .cnt     (cnt),
    .len     (len),
    .ext_vld (bus.ext_vld),
    .inst    (bus.inst)
  );

  assign bus.ext_req = (state == WR_K) || (state == WR_Q);
  assign bus.done    = (state == DONE);
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for the NPU run sequencer.
module tb_core_seq_ctrl;
  import core_seq_pkg::*;

  logic clk;
  logic reset;
  core_seq_if bus ();

  core_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run observations gathered by run_pass
  int kw_cnt, kw_bad, kw_novld, qw_cnt, qw_bad;
  int ld_cnt, ex_cnt, of_cnt, acc_cnt, div_cnt, divw_cnt, divw_bad;
  int overlap, done_cycle, done_cnt, post_busy, busy_first;
  int last_rd_cycle, last_rd_addr, first_div, rd_before_div, rd_addr_before_div;
  int first_wr2, first_wr2_addr;

  // Drives one run and records what the instruction word did each cycle
  task automatic run_pass(input logic [3:0] len, input bit bp, input bit late_start);
    int n;
    bit toggle;
    bit injected;
    logic [INST_W-1:0] w;
    kw_cnt = 0; kw_bad = 0; kw_novld = 0; qw_cnt = 0; qw_bad = 0;
    ld_cnt = 0; ex_cnt = 0; of_cnt = 0; acc_cnt = 0; div_cnt = 0;
    divw_cnt = 0; divw_bad = 0; overlap = 0; done_cycle = -1; done_cnt = 0;
    post_busy = 0; busy_first = 0; last_rd_cycle = -1; last_rd_addr = -1;
    first_div = -1; rd_before_div = -1; rd_addr_before_div = -1;
    first_wr2 = -1; first_wr2_addr = -1;
    n = 0; toggle = 1'b1; injected = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.len_m1 = len; bus.ext_vld = 1'b1;
    @(posedge clk);
    while (done_cycle < 0 && n < 300) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.len_m1 = len;
      if (bp && kw_cnt < int'(COL)) begin
        bus.ext_vld = toggle;
        toggle = ~toggle;
      end else begin
        bus.ext_vld = 1'b1;
      end
      if (late_start && !injected && of_cnt == 1) begin
        bus.start = 1'b1;
        bus.len_m1 = 4'd9;
        injected = 1'b1;
      end
      #1;
      w = bus.inst;
      if (n == 1) busy_first = int'(bus.busy);
      if (w[INST_KMEM_WR]) begin
        if (int'(w[15:12]) != kw_cnt) kw_bad++;
        if (!bus.ext_vld) kw_novld++;
        kw_cnt++;
      end
      if (w[INST_QMEM_WR]) begin
        if (int'(w[15:12]) != qw_cnt) qw_bad++;
        qw_cnt++;
      end
      if (w[INST_LOAD]) ld_cnt++;
      if (w[INST_EXECUTE]) ex_cnt++;
      if (w[INST_OFIFO_RD]) of_cnt++;
      if (w[INST_SFP_ACC]) acc_cnt++;
      if (w[INST_PMEM_RD] && w[INST_PMEM_WR]) overlap++;
      if (w[INST_PMEM_RD]) begin
        last_rd_cycle = n;
        last_rd_addr = int'(w[11:8]);
      end
      if (w[INST_SFP_DIV]) begin
        div_cnt++;
        if (first_div < 0) begin
          first_div = n;
          rd_before_div = last_rd_cycle;
          rd_addr_before_div = last_rd_addr;
        end
      end
      if (w[INST_SFP_WR2PMEM]) begin
        if (!w[INST_PMEM_WR] || int'(w[11:8]) != divw_cnt) divw_bad++;
        if (first_wr2 < 0) begin
          first_wr2 = n;
          first_wr2_addr = int'(w[11:8]);
        end
        divw_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cycle = n;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.done) done_cnt++;
      if (bus.busy) post_busy++;
    end
  endtask

  task automatic test_reset();
    int nz;
    int n;
    reset = 1'b0; bus.start = 1'b0; bus.len_m1 = '0; bus.ext_vld = 1'b0;
    #12;
    n_checks++;
    if (bus.inst !== 20'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ext_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: inst=%h busy=%b done=%b ext_req=%b, want all 0",
               bus.inst, bus.busy, bus.done, bus.ext_req);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.len_m1 = 4'd3; bus.ext_vld = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk); #1; n++;
      if (bus.inst[INST_EXECUTE]) break;
    end
    n_checks++;
    if (bus.inst[INST_EXECUTE] !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_exec: no EXEC cycle within %0d cycles", n);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.inst !== 20'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_exec: inst=%h busy=%b, want inst=0 busy=0", bus.inst, bus.busy);
    end
    @(negedge clk); reset = 1'b1;
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (bus.inst !== 20'h0 || bus.busy !== 1'b0) nz++;
    end
    n_checks++;
    if (nz !== 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: %0d non-idle cycles, want 0", nz);
    end
  endtask

  task automatic test_full_run();
    run_pass(4'd3, 1'b0, 1'b0);
    n_checks++;
    if (kw_cnt !== 8 || kw_bad !== 0) begin
      n_fail++; $display("FAIL full_kmem_wr: count=%0d bad_addr=%0d, want 8/0", kw_cnt, kw_bad);
    end
    n_checks++;
    if (qw_cnt !== 4 || qw_bad !== 0) begin
      n_fail++; $display("FAIL full_qmem_wr: count=%0d bad_addr=%0d, want 4/0", qw_cnt, qw_bad);
    end
    n_checks++;
    if (ld_cnt !== 9 || ex_cnt !== 5) begin
      n_fail++; $display("FAIL full_ld_exec: load=%0d exec=%0d, want 9/5", ld_cnt, ex_cnt);
    end
    n_checks++;
    if (done_cycle !== 58 || done_cnt !== 1) begin
      n_fail++; $display("FAIL full_done: cycle=%0d count=%0d, want 58/1", done_cycle, done_cnt);
    end
    n_checks++;
    if (of_cnt !== 4 || acc_cnt !== 4 || div_cnt !== 4) begin
      n_fail++;
      $display("FAIL full_post: ofifo=%0d acc=%0d div=%0d, want 4/4/4", of_cnt, acc_cnt, div_cnt);
    end
    n_checks++;
    if (divw_cnt !== 4 || divw_bad !== 0 || overlap !== 0) begin
      n_fail++;
      $display("FAIL full_div_wb: wr=%0d bad=%0d overlap=%0d, want 4/0/0", divw_cnt, divw_bad, overlap);
    end
    n_checks++;
    if (busy_first !== 1 || post_busy !== 0) begin
      n_fail++; $display("FAIL full_busy: first=%0d after=%0d, want 1/0", busy_first, post_busy);
    end
  endtask

  task automatic test_backpressure();
    run_pass(4'd3, 1'b1, 1'b0);
    n_checks++;
    if (kw_cnt !== 8 || kw_bad !== 0 || kw_novld !== 0) begin
      n_fail++;
      $display("FAIL bp_kmem_wr: count=%0d bad_addr=%0d novld=%0d, want 8/0/0", kw_cnt, kw_bad, kw_novld);
    end
    n_checks++;
    if (done_cycle !== 65) begin
      n_fail++; $display("FAIL bp_done: cycle=%0d, want 65", done_cycle);
    end
  endtask

  task automatic test_max_len();
    run_pass(4'd15, 1'b0, 1'b0);
    n_checks++;
    if (qw_cnt !== 16 || qw_bad !== 0 || ex_cnt !== 17) begin
      n_fail++;
      $display("FAIL max_q_exec: qwr=%0d bad=%0d exec=%0d, want 16/0/17", qw_cnt, qw_bad, ex_cnt);
    end
    n_checks++;
    if (divw_cnt !== 16 || divw_bad !== 0) begin
      n_fail++; $display("FAIL max_div_wb: wr=%0d bad=%0d, want 16/0", divw_cnt, divw_bad);
    end
    n_checks++;
    if (done_cycle !== 142 || overlap !== 0) begin
      n_fail++; $display("FAIL max_done: cycle=%0d overlap=%0d, want 142/0", done_cycle, overlap);
    end
  endtask

  task automatic test_div_order();
    run_pass(4'd0, 1'b0, 1'b0);
    n_checks++;
    if (first_div < 0 || rd_before_div !== first_div - 1 || rd_addr_before_div !== 0) begin
      n_fail++;
      $display("FAIL div_rd_then_div: rd_cycle=%0d rd_addr=%0d div_cycle=%0d, want rd one before div at addr 0",
               rd_before_div, rd_addr_before_div, first_div);
    end
    n_checks++;
    if (first_wr2 !== first_div + 1 || first_wr2_addr !== 0 || divw_cnt !== 1) begin
      n_fail++;
      $display("FAIL div_wb: wr_cycle=%0d addr=%0d count=%0d, want %0d/0/1",
               first_wr2, first_wr2_addr, divw_cnt, first_div + 1);
    end
    n_checks++;
    if (overlap !== 0 || done_cycle !== 37) begin
      n_fail++; $display("FAIL div_len0: overlap=%0d done=%0d, want 0/37", overlap, done_cycle);
    end
  endtask

  task automatic test_start_while_busy();
    run_pass(4'd3, 1'b0, 1'b1);
    n_checks++;
    if (done_cnt !== 1 || done_cycle !== 58) begin
      n_fail++; $display("FAIL busy_start_done: count=%0d cycle=%0d, want 1/58", done_cnt, done_cycle);
    end
    n_checks++;
    if (of_cnt !== 4 || div_cnt !== 4 || divw_cnt !== 4) begin
      n_fail++;
      $display("FAIL busy_start_len: ofifo=%0d div=%0d wb=%0d, want 4/4/4", of_cnt, div_cnt, divw_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
    test_max_len();
    test_div_order();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
